// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared sequencer types and constants (package kgp_risc_pkg)
package kgp_risc_pkg;

  typedef enum logic [2:0] {
    BOOT      = 3'd0,
    FETCH     = 3'd1,
    EXEC      = 3'd2,
    STEP_WAIT = 3'd3,
    HALT      = 3'd4
  } seqState_t;

  localparam logic [4:0] HALT_OPCODE_DEF    = 5'b11111;
  localparam int         DEFAULT_IMEM_DEPTH = 1024;
  localparam int         DEFAULT_BOOT_ADDR  = 0;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - sequencer <-> datapath bundle; trace signals exist only with PC_SEQ_TRACE_EN
interface pc_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);

  logic [ADDR_W-1:0] nextInstrAddr;
  logic [4:0]        opcode;
  logic [ADDR_W-1:0] instrAddr;
  logic              commit_en;
  logic              halted;
  logic              fault;
  logic [CNT_W-1:0]  retired;
`ifdef PC_SEQ_TRACE_EN
  logic [ADDR_W-1:0] last_jump_src;
  logic [ADDR_W-1:0] last_jump_dst;
`endif

  // Sequencer side: owns the PC and the commit qualifier.
  modport master (
    input  nextInstrAddr,
    input  opcode,
    output instrAddr,
    output commit_en,
    output halted,
    output fault,
`ifdef PC_SEQ_TRACE_EN
    output last_jump_src,
    output last_jump_dst,
`endif
    output retired
  );

  // Datapath side: consumes the PC, supplies the next PC and opcode.
  modport slave (
    output nextInstrAddr,
    output opcode,
    input  instrAddr,
    input  commit_en,
    input  halted,
    input  fault,
`ifdef PC_SEQ_TRACE_EN
    input  last_jump_src,
    input  last_jump_dst,
`endif
    input  retired
  );

endinterface

// File: rtl/pc_sequencer_step_edge_detect.sv
// rtl/pc_sequencer_step_edge_detect.sv - 2-flop synchroniser plus rising-edge pulse for the step button
module step_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic asyncIn,
  output logic risePulse
);

  logic metaQ;
  logic syncQ;
  logic prevQ;

  // Two flops for metastability, a third remembers the previous synced level.
  always_ff @(posedge clk) begin
    if (rst) begin
      metaQ <= 1'b0;
      syncQ <= 1'b0;
      prevQ <= 1'b0;
    end else begin
      metaQ <= asyncIn;
      syncQ <= metaQ;
      prevQ <= syncQ;
    end
  end

  // One-cycle pulse per rising edge, so a held button yields a single step.
  assign risePulse = syncQ & ~prevQ;

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with fetch stall, single-step, halt/fault; trace via PC_SEQ_TRACE_EN
module pc_sequencer
  import kgp_risc_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                IMEM_DEPTH  = DEFAULT_IMEM_DEPTH,
  parameter logic [ADDR_W-1:0] BOOT_ADDR   = ADDR_W'(DEFAULT_BOOT_ADDR),
  parameter int                FETCH_WAIT  = 1,
  parameter int                CNT_W       = 32,
  parameter logic [4:0]        HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           step_mode,
  input  logic           step_btn,
  pc_sequencer_if.master bus
);

  localparam int                WAIT_W      = (FETCH_WAIT > 1) ? $clog2(FETCH_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_RELOAD = WAIT_W'(FETCH_WAIT - 1);
  localparam logic [ADDR_W:0]   DEPTH_LIMIT = (ADDR_W + 1)'(IMEM_DEPTH);

  seqState_t         state;
  seqState_t         stateNext;
  logic [WAIT_W-1:0] waitCnt;
  logic [WAIT_W-1:0] waitCntNext;
  logic [ADDR_W-1:0] pcReg;
  logic [CNT_W-1:0]  retiredReg;
  logic              faultReg;
  logic              modeMeta;
  logic              modeSync;
  logic              stepPulse;
  logic              commitEn;
  logic              pcLoad;
  logic              cntInc;
  logic              faultSet;
  logic              isHaltOp;
  logic              outOfRange;

  assign isHaltOp   = (bus.opcode == HALT_OPCODE);
  assign outOfRange = ({1'b0, bus.nextInstrAddr} >= DEPTH_LIMIT);

  // step_mode is a level, so it only needs the synchroniser, not the edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      modeMeta <= 1'b0;
      modeSync <= 1'b0;
    end else begin
      modeMeta <= step_mode;
      modeSync <= modeMeta;
    end
  end

  step_edge_detect u_stepBtn (
    .clk       (clk),
    .rst       (rst),
    .asyncIn   (step_btn),
    .risePulse (stepPulse)
  );

  // Next-state and per-cycle strobes; halt opcode takes priority over the range check.
  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    commitEn    = 1'b0;
    pcLoad      = 1'b0;
    cntInc      = 1'b0;
    faultSet    = 1'b0;
    case (state)
      BOOT: begin
        waitCntNext = WAIT_RELOAD;
        stateNext   = FETCH;
      end
      FETCH: begin
        if (waitCnt == '0) begin
          stateNext = EXEC;
        end else begin
          waitCntNext = waitCnt - WAIT_W'(1);
        end
      end
      EXEC: begin
        if (isHaltOp) begin
          stateNext = HALT;
        end else if (outOfRange) begin
          // The instruction itself is legal; only its successor is not, so it still commits.
          commitEn  = 1'b1;
          cntInc    = 1'b1;
          faultSet  = 1'b1;
          stateNext = HALT;
        end else begin
          commitEn    = 1'b1;
          cntInc      = 1'b1;
          pcLoad      = 1'b1;
          waitCntNext = WAIT_RELOAD;
          stateNext   = modeSync ? STEP_WAIT : FETCH;
        end
      end
      STEP_WAIT: begin
        if (stepPulse || !modeSync) begin
          stateNext = FETCH;
        end
      end
      HALT: begin
        stateNext = HALT;
      end
      default: begin
        stateNext = BOOT;
      end
    endcase
  end

  // State, PC, retired counter and sticky fault; reset overrides any commit in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT;
      waitCnt    <= '0;
      pcReg      <= BOOT_ADDR;
      retiredReg <= '0;
      faultReg   <= 1'b0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      if (pcLoad) begin
        pcReg <= bus.nextInstrAddr;
      end
      if (cntInc && (retiredReg != '1)) begin
        retiredReg <= retiredReg + CNT_W'(1);
      end
      if (faultSet) begin
        faultReg <= 1'b1;
      end
    end
  end

  // Masking with rst keeps the datapath from writing in a cycle that reset discards.
  assign bus.commit_en = commitEn & ~rst;
  assign bus.instrAddr = pcReg;
  assign bus.halted    = (state == HALT);
  assign bus.fault     = faultReg;
  assign bus.retired   = retiredReg;

`ifdef PC_SEQ_TRACE_EN
  logic [ADDR_W-1:0] jumpSrc;
  logic [ADDR_W-1:0] jumpDst;
  logic              isJump;

  assign isJump = (bus.nextInstrAddr != (pcReg + ADDR_W'(1)));

  // Remember the most recent non-sequential, in-range PC change.
  always_ff @(posedge clk) begin
    if (rst) begin
      jumpSrc <= '0;
      jumpDst <= '0;
    end else if (pcLoad && isJump) begin
      jumpSrc <= pcReg;
      jumpDst <= bus.nextInstrAddr;
    end
  end

  assign bus.last_jump_src = jumpSrc;
  assign bus.last_jump_dst = jumpDst;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        step_mode;
  logic        step_btn;
  logic        useOverride;
  logic [31:0] overrideAddr;
  int          passCnt  = 0;
  int          failCnt  = 0;
  int          totalCnt = 0;

  pc_sequencer_if #(.ADDR_W(32), .CNT_W(32)) bus ();

  pc_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .step_mode (step_mode),
    .step_btn  (step_btn),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: sequential next PC unless a branch target is forced.
  always_comb bus.nextInstrAddr = useOverride ? overrideAddr : (bus.instrAddr + 32'd1);

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCnt = totalCnt + 1;
    assert (obs === exp) passCnt = passCnt + 1;
    else begin
      failCnt = failCnt + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    rst          = 1'b1;
    step_mode    = 1'b0;
    step_btn     = 1'b0;
    bus.opcode   = 5'd0;
    useOverride  = 1'b0;
    overrideAddr = 32'd0;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    doReset();
    check("rst_pc", 64'(bus.instrAddr), 64'd0);
    check("rst_commit", 64'(bus.commit_en), 64'd0);
    check("rst_halted", 64'(bus.halted), 64'd0);
    check("rst_fault", 64'(bus.fault), 64'd0);
    check("rst_retired", 64'(bus.retired), 64'd0);

    // Free-run: one commit every 2 cycles, PC 0,1,2,3
    tick(2);
    for (int i = 0; i < 3; i++) begin
      check("run_exec_commit", 64'(bus.commit_en), 64'd1);
      check("run_exec_pc", 64'(bus.instrAddr), 64'(i));
      tick(1);
      check("run_fetch_commit", 64'(bus.commit_en), 64'd0);
      check("run_fetch_pc", 64'(bus.instrAddr), 64'(i + 1));
      tick(1);
    end
    check("run_retired3", 64'(bus.retired), 64'd3);

    // Halt at PC 5
    tick(3);
    check("halt_pre_pc", 64'(bus.instrAddr), 64'd5);
    bus.opcode = 5'b11111;
    tick(1);
    check("halt_exec_commit", 64'(bus.commit_en), 64'd0);
    check("halt_exec_halted", 64'(bus.halted), 64'd0);
    tick(1);
    check("halt_halted", 64'(bus.halted), 64'd1);
    check("halt_pc", 64'(bus.instrAddr), 64'd5);
    check("halt_retired", 64'(bus.retired), 64'd5);
    step_btn = 1'b1;
    tick(6);
    step_btn = 1'b0;
    tick(3);
    check("halt_btn_pc", 64'(bus.instrAddr), 64'd5);
    check("halt_btn_commit", 64'(bus.commit_en), 64'd0);
    check("halt_btn_retired", 64'(bus.retired), 64'd5);
    check("halt_btn_fault", 64'(bus.fault), 64'd0);

    // Fault: 1023 is legal, 1024 is not
    doReset();
    check("flt_rst_halted", 64'(bus.halted), 64'd0);
    tick(2);
    useOverride  = 1'b1;
    overrideAddr = 32'd1023;
    #1;
    check("flt_exec0_commit", 64'(bus.commit_en), 64'd1);
    tick(2);
    check("flt_pc1023", 64'(bus.instrAddr), 64'd1023);
    check("flt_1023_halted", 64'(bus.halted), 64'd0);
    overrideAddr = 32'd1024;
    #1;
    check("flt_oor_commit", 64'(bus.commit_en), 64'd1);
    tick(1);
    check("flt_halted", 64'(bus.halted), 64'd1);
    check("flt_fault", 64'(bus.fault), 64'd1);
    check("flt_pc_kept", 64'(bus.instrAddr), 64'd1023);
    check("flt_retired", 64'(bus.retired), 64'd2);
    check("flt_commit_after", 64'(bus.commit_en), 64'd0);

    // Reset during EXEC
    doReset();
    check("mid_rst_fault", 64'(bus.fault), 64'd0);
    tick(4);
    check("mid_exec_commit", 64'(bus.commit_en), 64'd1);
    check("mid_exec_pc", 64'(bus.instrAddr), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_commit_masked", 64'(bus.commit_en), 64'd0);
    tick(1);
    check("mid_pc", 64'(bus.instrAddr), 64'd0);
    check("mid_retired", 64'(bus.retired), 64'd0);
    check("mid_halted", 64'(bus.halted), 64'd0);
    rst = 1'b0;
    tick(2);
    check("mid_restart_commit", 64'(bus.commit_en), 64'd1);

    // Single-step
    doReset();
    step_mode = 1'b1;
    tick(2);
    check("step_first_commit", 64'(bus.commit_en), 64'd1);
    tick(6);
    check("step_wait_pc", 64'(bus.instrAddr), 64'd1);
    check("step_wait_commit", 64'(bus.commit_en), 64'd0);
    check("step_wait_retired", 64'(bus.retired), 64'd1);
    step_btn = 1'b1;
    tick(3);
    check("step1_early_commit", 64'(bus.commit_en), 64'd0);
    tick(1);
    check("step1_commit", 64'(bus.commit_en), 64'd1);
    tick(1);
    check("step1_pc", 64'(bus.instrAddr), 64'd2);
    tick(18);
    check("step_held_pc", 64'(bus.instrAddr), 64'd2);
    check("step_held_retired", 64'(bus.retired), 64'd2);
    step_btn = 1'b0;
    tick(3);
    step_btn = 1'b1;
    tick(3);
    check("step2_early_commit", 64'(bus.commit_en), 64'd0);
    tick(1);
    check("step2_commit", 64'(bus.commit_en), 64'd1);
    tick(1);
    check("step2_pc", 64'(bus.instrAddr), 64'd3);
    step_btn = 1'b0;
    tick(3);
    // Button edge and mode drop together: one step, then free-run
    step_btn  = 1'b1;
    step_mode = 1'b0;
    tick(4);
    check("both_commit", 64'(bus.commit_en), 64'd1);
    tick(1);
    check("both_pc", 64'(bus.instrAddr), 64'd4);
    check("both_retired", 64'(bus.retired), 64'd4);
    tick(1);
    check("both_freerun_commit", 64'(bus.commit_en), 64'd1);
    step_btn = 1'b0;

`ifdef PC_SEQ_TRACE_EN
    // Trace: 0 -> 7 -> 2 -> 3
    doReset();
    check("trc_rst_src", 64'(bus.last_jump_src), 64'd0);
    tick(2);
    useOverride  = 1'b1;
    overrideAddr = 32'd7;
    tick(2);
    overrideAddr = 32'd2;
    tick(2);
    check("trc_src", 64'(bus.last_jump_src), 64'd7);
    check("trc_dst", 64'(bus.last_jump_dst), 64'd2);
    useOverride = 1'b0;
    tick(2);
    check("trc_seq_pc", 64'(bus.instrAddr), 64'd3);
    check("trc_seq_src", 64'(bus.last_jump_src), 64'd7);
    check("trc_seq_dst", 64'(bus.last_jump_dst), 64'd2);
`endif

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
